vtisa_mem_responder: RTL and testbench

Memory-side target for the vtisa CPU pin bus. It sits on the far side of the CPU's `data_out`/`rom_ram`/`addr_data` pins, for example in the companion FPGA or in the bench harness. It decodes the two-cycle address/data protocol the CPU initiates, serves reads from an internal ROM or RAM, and applies writes. Its `data_out` drives the CPU's `data_in` pins.

---
 rtl/vtisa_mem_responder.sv | 152 +++++++++++++++
 tb/tb_vtisa_mem_responder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/vtisa_mem_responder.sv
// Memory-side target for the vtisa CPU pin bus: decodes address/data cycles and serves ROM/RAM.
// Define VTISA_ROM_PROG_EN to enable the ROM program port and make ROM read-only from the bus.
module vtisa_mem_responder #(
    parameter int ROM_DEPTH = 32,
    parameter int RAM_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] bus_in,
    input  logic       rom_ram,
    input  logic       addr_data,
    output logic [7:0] data_out,
    output logic       txn_done,
    input  logic       prog_we,
    input  logic [7:0] prog_addr,
    input  logic [7:0] prog_data
);

    localparam int ROM_AW = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
    localparam int RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    typedef enum logic {
        IDLE,
        ADDR
    } state_t;

    state_t state;
    state_t next_state;

    logic              latch_addr;
    logic              do_txn;
    logic              do_write;
    logic [7:0]        addr_q;
    logic              space_q;
    logic [7:0]        rd_data;
    logic              ram_we;
    logic              rom_bus_we;
    logic [ROM_AW-1:0] rom_rd_idx;
    logic [ROM_AW-1:0] rom_wr_idx;
    logic [RAM_AW-1:0] ram_rd_idx;
    logic [RAM_AW-1:0] ram_wr_idx;
    logic              unused_sink;

    logic [7:0] rom_mem [ROM_DEPTH];
    logic [7:0] ram_mem [RAM_DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        latch_addr = 1'b0;
        do_txn     = 1'b0;
        do_write   = 1'b0;
        case (state)
            IDLE: begin
                if (addr_data) begin
                    latch_addr = 1'b1;
                    next_state = ADDR;
                end
            end
            ADDR: begin
                // A second address cycle restarts the transaction without completing it.
                if (addr_data) begin
                    latch_addr = 1'b1;
                end else begin
                    do_txn     = 1'b1;
                    do_write   = rom_ram;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Only the low bits of the address byte index each array, so addresses wrap.
    assign rom_rd_idx = bus_in[ROM_AW-1:0];
    assign ram_rd_idx = bus_in[RAM_AW-1:0];
    assign rom_wr_idx = addr_q[ROM_AW-1:0];
    assign ram_wr_idx = addr_q[RAM_AW-1:0];

    always_comb begin
        rd_data = 8'h00;
        if (rom_ram) begin
            rd_data = ram_mem[ram_rd_idx];
        end else begin
            rd_data = rom_mem[rom_rd_idx];
        end
    end

    assign ram_we = do_write & space_q;
`ifdef VTISA_ROM_PROG_EN
    assign rom_bus_we  = 1'b0;
    assign unused_sink = &{1'b0, addr_q, prog_addr, do_write};
`else
    assign rom_bus_we  = do_write & ~space_q;
    assign unused_sink = &{1'b0, addr_q, prog_we, prog_addr, prog_data};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= 8'h00;
            txn_done <= 1'b0;
            addr_q   <= 8'h00;
            space_q  <= 1'b0;
        end else begin
            txn_done <= do_txn;
            if (latch_addr) begin
                addr_q   <= bus_in;
                space_q  <= rom_ram;
                data_out <= rd_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RAM_DEPTH; i++) begin
                ram_mem[i] <= 8'h00;
            end
        end else if (ram_we) begin
            ram_mem[ram_wr_idx] <= bus_in;
        end
    end

    // Reads above sample the pre-edge contents, so a same-edge program write returns old data.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ROM_DEPTH; i++) begin
                rom_mem[i] <= 8'h00;
            end
        end else begin
`ifdef VTISA_ROM_PROG_EN
            if (prog_we) begin
                rom_mem[prog_addr[ROM_AW-1:0]] <= prog_data;
            end
`else
            if (rom_bus_we) begin
                rom_mem[rom_wr_idx] <= bus_in;
            end
`endif
        end
    end

endmodule

// File: tb/tb_vtisa_mem_responder.sv
// Self-checking bench for vtisa_mem_responder: directed vector table plus randomized model comparison.
module tb_vtisa_mem_responder;

    localparam int ROM_DEPTH = 32;
    localparam int RAM_DEPTH = 16;
`ifdef VTISA_ROM_PROG_EN
    localparam bit PROG_EN = 1'b1;
`else
    localparam bit PROG_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] bus_in;
    logic       rom_ram;
    logic       addr_data;
    logic [7:0] data_out;
    logic       txn_done;
    logic       prog_we;
    logic [7:0] prog_addr;
    logic [7:0] prog_data;

    int checks;
    int errors;

    typedef struct {
        logic       rst;
        logic       ad;
        logic       rr;
        logic [7:0] bus;
        logic       pwe;
        logic [7:0] paddr;
        logic [7:0] pdata;
        logic [7:0] exp_data;
        logic       exp_done;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model: memory contents plus "an address has been seen" flag.
    logic [7:0] m_rom [ROM_DEPTH];
    logic [7:0] m_ram [RAM_DEPTH];
    bit         m_pending;
    logic [7:0] m_addr;
    logic       m_space;
    logic [7:0] m_data;
    logic       m_done;

    vtisa_mem_responder #(
        .ROM_DEPTH(ROM_DEPTH),
        .RAM_DEPTH(RAM_DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus_in   (bus_in),
        .rom_ram  (rom_ram),
        .addr_data(addr_data),
        .data_out (data_out),
        .txn_done (txn_done),
        .prog_we  (prog_we),
        .prog_addr(prog_addr),
        .prog_data(prog_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add_vec(input logic rst, input logic ad, input logic rr,
                                    input logic [7:0] bus, input logic pwe,
                                    input logic [7:0] paddr, input logic [7:0] pdata,
                                    input logic [7:0] exp_data, input logic exp_done);
        vec_t v;
        v.rst = rst; v.ad = ad; v.rr = rr; v.bus = bus;
        v.pwe = pwe; v.paddr = paddr; v.pdata = pdata;
        v.exp_data = exp_data; v.exp_done = exp_done;
        vecs.push_back(v);
    endfunction

    task automatic apply_stimulus(input logic rst, input logic ad, input logic rr,
                                  input logic [7:0] bus, input logic pwe,
                                  input logic [7:0] paddr, input logic [7:0] pdata);
        reset     = rst;
        addr_data = ad;
        rom_ram   = rr;
        bus_in    = bus;
        prog_we   = pwe;
        prog_addr = paddr;
        prog_data = pdata;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [7:0] exp_data, input logic exp_done);
        checks++;
        if (data_out !== exp_data) begin
            errors++;
            $display("[TB] FAIL %s data_out: got %02h expected %02h", name, data_out, exp_data);
        end
        checks++;
        if (txn_done !== exp_done) begin
            errors++;
            $display("[TB] FAIL %s txn_done: got %0b expected %0b", name, txn_done, exp_done);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < ROM_DEPTH; i++) m_rom[i] = 8'h00;
        for (int i = 0; i < RAM_DEPTH; i++) m_ram[i] = 8'h00;
        m_pending = 1'b0;
        m_addr    = 8'h00;
        m_space   = 1'b0;
        m_data    = 8'h00;
        m_done    = 1'b0;
    endfunction

    function automatic void model_step(input logic rst, input logic ad, input logic rr,
                                       input logic [7:0] bus, input logic pwe,
                                       input logic [7:0] paddr, input logic [7:0] pdata);
        if (rst) begin
            model_reset();
            return;
        end
        m_done = 1'b0;
        if (ad) begin
            m_data    = rr ? m_ram[bus % RAM_DEPTH] : m_rom[bus % ROM_DEPTH];
            m_addr    = bus;
            m_space   = rr;
            m_pending = 1'b1;
        end else if (m_pending) begin
            m_done    = 1'b1;
            m_pending = 1'b0;
            if (rr) begin
                if (m_space) m_ram[m_addr % RAM_DEPTH] = bus;
                else if (!PROG_EN) m_rom[m_addr % ROM_DEPTH] = bus;
            end
        end
        if (PROG_EN && pwe) m_rom[paddr % ROM_DEPTH] = pdata;
    endfunction

    initial begin
        logic [7:0] rom7;
        logic [7:0] rom7b;
        checks = 0;
        errors = 0;

        rom7  = PROG_EN ? 8'h3E : 8'h11;
        rom7b = PROG_EN ? 8'h42 : 8'h11;
        //       rst ad rr bus    pwe paddr  pdata  data   done
        add_vec(0, 0, 1, 8'h55, 0, 8'h00, 8'h00, 8'h00, 0);
        add_vec(0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0);
        add_vec(0, 1, 1, 8'h03, 0, 8'h00, 8'h00, 8'h00, 0);
        add_vec(0, 0, 1, 8'hA5, 0, 8'h00, 8'h00, 8'h00, 1);
        add_vec(0, 1, 1, 8'h03, 0, 8'h00, 8'h00, 8'hA5, 0);
        add_vec(0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'hA5, 1);
        add_vec(0, 1, 1, 8'h13, 0, 8'h00, 8'h00, 8'hA5, 0);
        add_vec(0, 0, 1, 8'h5C, 0, 8'h00, 8'h00, 8'hA5, 1);
        add_vec(0, 1, 1, 8'h03, 0, 8'h00, 8'h00, 8'h5C, 0);
        add_vec(0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h5C, 1);
        add_vec(0, 0, 0, 8'h00, 1, 8'h07, 8'h3E, 8'h5C, 0);
        add_vec(0, 1, 0, 8'h07, 0, 8'h00, 8'h00, PROG_EN ? 8'h3E : 8'h00, 0);
        add_vec(0, 0, 0, 8'h00, 0, 8'h00, 8'h00, PROG_EN ? 8'h3E : 8'h00, 1);
        add_vec(0, 1, 0, 8'h07, 0, 8'h00, 8'h00, PROG_EN ? 8'h3E : 8'h00, 0);
        add_vec(0, 0, 1, PROG_EN ? 8'hFF : 8'h11, 0, 8'h00, 8'h00, PROG_EN ? 8'h3E : 8'h00, 1);
        add_vec(0, 1, 0, 8'h07, 0, 8'h00, 8'h00, rom7, 0);
        add_vec(0, 0, 0, 8'h00, 0, 8'h00, 8'h00, rom7, 1);
        add_vec(0, 1, 0, 8'h07, 1, 8'h07, 8'h42, rom7, 0);
        add_vec(0, 0, 0, 8'h00, 0, 8'h00, 8'h00, rom7, 1);
        add_vec(0, 1, 0, 8'h27, 0, 8'h00, 8'h00, rom7b, 0);
        add_vec(0, 0, 0, 8'h00, 0, 8'h00, 8'h00, rom7b, 1);
        add_vec(0, 1, 1, 8'h01, 0, 8'h00, 8'h00, 8'h00, 0);
        add_vec(0, 1, 1, 8'h02, 0, 8'h00, 8'h00, 8'h00, 0);
        add_vec(0, 0, 1, 8'h77, 0, 8'h00, 8'h00, 8'h00, 1);
        add_vec(0, 1, 1, 8'h01, 0, 8'h00, 8'h00, 8'h00, 0);
        add_vec(0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 1);
        add_vec(0, 1, 1, 8'h02, 0, 8'h00, 8'h00, 8'h77, 0);
        add_vec(0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h77, 1);
        add_vec(0, 1, 1, 8'h04, 0, 8'h00, 8'h00, 8'h00, 0);
        add_vec(1, 0, 1, 8'h99, 0, 8'h00, 8'h00, 8'h00, 0);
        add_vec(0, 1, 1, 8'h04, 0, 8'h00, 8'h00, 8'h00, 0);
        add_vec(0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 1);
        add_vec(0, 1, 1, 8'h02, 0, 8'h00, 8'h00, 8'h00, 0);
        add_vec(0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 1);
        add_vec(1, 0, 0, 8'h00, 1, 8'h05, 8'hAA, 8'h00, 0);
        add_vec(0, 1, 0, 8'h05, 0, 8'h00, 8'h00, 8'h00, 0);
        add_vec(0, 0, 0, 8'h00, 0, 8'h00, 8'h00, 8'h00, 1);

        apply_stimulus(1, 0, 0, 8'h00, 0, 8'h00, 8'h00);
        apply_stimulus(1, 0, 0, 8'h00, 0, 8'h00, 8'h00);
        check_output("reset", 8'h00, 1'b0);

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].rst, vecs[i].ad, vecs[i].rr, vecs[i].bus,
                           vecs[i].pwe, vecs[i].paddr, vecs[i].pdata);
            check_output($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_done);
        end

        // Randomized traffic against the model, starting from a clean reset.
        apply_stimulus(1, 0, 0, 8'h00, 0, 8'h00, 8'h00);
        model_reset();
        for (int n = 0; n < 600; n++) begin
            logic       rst;
            logic       ad;
            logic       rr;
            logic [7:0] bus;
            logic       pwe;
            logic [7:0] paddr;
            logic [7:0] pdata;
            rst   = ($urandom_range(0, 59) == 0);
            ad    = ($urandom_range(0, 9) < 5);
            rr    = $urandom_range(0, 1);
            bus   = 8'($urandom_range(0, 255));
            pwe   = ($urandom_range(0, 3) == 0);
            paddr = 8'($urandom_range(0, 255));
            pdata = 8'($urandom_range(0, 255));
            apply_stimulus(rst, ad, rr, bus, pwe, paddr, pdata);
            model_step(rst, ad, rr, bus, pwe, paddr, pdata);
            check_output($sformatf("rand%0d", n), m_data, m_done);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
